// File: rtl/fpu_round_pkg.sv
// fpu_round_pkg: shared widths, exponent helpers and pipeline stage structs for the rounding path
package fpu_round_pkg;
  localparam int NS_FR_W = 57;
  localparam int NS_ER_W = 13;
  localparam int NS_EN_W = 11;
  localparam int NS_LZ_W = $clog2(NS_FR_W);
  localparam int NS_SH_W = $clog2(NS_FR_W + 1);
  function automatic int bias(input int w);
    return 2 ** (w - 1) - 1;
  endfunction
  function automatic int alpha(input int w);
    return 3 * 2 ** (w - 2);
  endfunction
  function automatic int emin(input int w);
    return 1 - bias(w);
  endfunction
  function automatic int emax(input int w);
    return bias(w);
  endfunction
  typedef struct packed {
    logic [NS_FR_W-1:0] fr;
    logic [NS_ER_W-1:0] er;
    logic [NS_LZ_W-1:0] lz;
    logic               rs;
    logic               zero;
    logic               ovfen;
    logic               unfen;
  } ns_s1_t;
  typedef struct packed {
    logic [NS_FR_W-1:0] fr;
    logic [NS_SH_W-1:0] shamt;
    logic               dir;
    logic [NS_EN_W-1:0] en;
    logic               tiny;
    logic               ovf1;
  } ns_s2_t;
endpackage

// File: rtl/normshift_pipe_if.sv
// normshift_pipe_if: operand/result valid-ready bundle of the normalisation shifter
//   master drives in_valid/fr/er/OVFen/UNFen/out_ready; slave drives in_ready/out_valid/fn/en/eni/TINY/OVF1
interface normshift_pipe_if #(
  parameter int FR_W = 57,
  parameter int ER_W = 13,
  parameter int EN_W = 11
);
  logic            in_valid, in_ready, OVFen, UNFen;
  logic [FR_W-1:0] fr;
  logic [ER_W-1:0] er;
  logic            out_valid, out_ready, TINY, OVF1;
  logic [FR_W-2:0] fn;
  logic [EN_W-1:0] en, eni;
  modport master (
    output in_valid, fr, er, OVFen, UNFen, out_ready,
    input  in_ready, out_valid, fn, en, eni, TINY, OVF1
  );
  modport slave (
    input  in_valid, fr, er, OVFen, UNFen, out_ready,
    output in_ready, out_valid, fn, en, eni, TINY, OVF1
  );
endinterface

// File: rtl/lzc_tree.sv
// lzc_tree: combinational leading-zero counter; d in, cnt out (cnt=W when d is all zero)
module lzc_tree #(
  parameter int W  = 56,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] cnt
);
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) if (d[i]) cnt = CW'(W - 1 - i);
  end
endmodule

// File: rtl/normshift_pipe.sv
// normshift_pipe: 3-stage normaliser with denormal clamping and trap exponent wrapping
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : normshift_pipe_if.slave (fr/er/OVFen/UNFen in over in_valid/in_ready,
//           fn/en/eni/TINY/OVF1 out over out_valid/out_ready)
module normshift_pipe
  import fpu_round_pkg::*;
#(
  parameter int FR_W = NS_FR_W,
  parameter int ER_W = NS_ER_W,
  parameter int EN_W = NS_EN_W
) (
  input logic           clk,
  input logic           rst_n,
  normshift_pipe_if.slave bus
);
  localparam int XE_W = ER_W + 2;
  localparam logic signed [XE_W-1:0] EMIN_X  = XE_W'(emin(EN_W));
  localparam logic signed [XE_W-1:0] EMAX_X  = XE_W'(emax(EN_W));
  localparam logic signed [XE_W-1:0] ALPHA_X = XE_W'(alpha(EN_W));
  localparam logic signed [XE_W-1:0] BIAS_X  = XE_W'(bias(EN_W));
  localparam logic signed [XE_W-1:0] FR_X    = XE_W'(FR_W);
  localparam logic signed [XE_W-1:0] ONE_X   = XE_W'(1);
  logic                     adv, s1_v, s2_v, tiny, ovf1, den;
  logic [NS_LZ_W-1:0]       lz;
  ns_s1_t                   s1;
  ns_s2_t                   s2, s2_d;
  logic signed [XE_W-1:0]   er_x, lz_x, e1, e2, d;
  logic [2*FR_W-2:0]        rsh;
  logic [FR_W-2:0]          lsh, fn_d;
  // all stages move in lockstep; a stalled output freezes the whole pipe
  assign adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  lzc_tree #(.W(FR_W - 1), .CW(NS_LZ_W)) u_lzc (.d(bus.fr[FR_W-2:0]), .cnt(lz));
  always_comb begin
    er_x = {{2{s1.er[ER_W-1]}}, s1.er};
    lz_x = XE_W'(s1.lz);
    e1 = s1.rs ? er_x + ONE_X : er_x - lz_x;
    tiny = !s1.zero && e1 < EMIN_X;
    ovf1 = !s1.zero && e1 > EMAX_X;
    den = tiny && !s1.unfen;
    // denormal placement relative to the unshifted fr; negative means a left shift
    d = s1.rs ? EMIN_X - e1 + ONE_X : EMIN_X - e1 - lz_x;
    e2 = tiny ? e1 + ALPHA_X : (ovf1 && s1.ovfen) ? e1 - ALPHA_X : e1;
    s2_d.fr = s1.fr;
    s2_d.dir = den ? d > 0 : s1.rs;
    s2_d.shamt = !den ? (s1.rs ? NS_SH_W'(1) : NS_SH_W'(s1.lz))
               : d > FR_X ? NS_SH_W'(FR_W) : d > 0 ? NS_SH_W'(d) : NS_SH_W'(-d);
    s2_d.en = (s1.zero || den) ? '0 : (ovf1 && !s1.ovfen) ? '1 : EN_W'(e2 + BIAS_X);
    s2_d.tiny = tiny;
    s2_d.ovf1 = ovf1;
  end
  // right shift keeps shifted-out bits in the low half for the sticky OR
  always_comb begin
    rsh = (2*FR_W-1)'({s2.fr, {FR_W{1'b0}}} >> s2.shamt);
    lsh = s2.fr[FR_W-2:0] << s2.shamt;
    fn_d = s2.dir ? {rsh[2*FR_W-2:FR_W+1], rsh[FR_W] | (|rsh[FR_W-1:0])} : lsh;
  end
  always_ff @(posedge clk)
    if (adv) begin
      if (bus.in_valid) s1 <= '{fr: bus.fr, er: bus.er, lz: lz, rs: bus.fr[FR_W-1],
                                zero: bus.fr == '0, ovfen: bus.OVFen, unfen: bus.UNFen};
      if (s1_v) s2 <= s2_d;
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.fn <= '0;
      bus.en <= '0;
      bus.eni <= '0;
      bus.TINY <= 1'b0;
      bus.OVF1 <= 1'b0;
    end else if (adv) begin
      s1_v <= bus.in_valid;
      s2_v <= s1_v;
      bus.out_valid <= s2_v;
      if (s2_v) begin
        bus.fn <= fn_d;
        bus.en <= s2.en;
        bus.eni <= s2.en + 1'b1;
        bus.TINY <= s2.tiny;
        bus.OVF1 <= s2.ovf1;
      end
    end
endmodule

// File: tb/tb_normshift_pipe.sv
// tb_normshift_pipe: randomized scoreboard bench for normshift_pipe against an arithmetic reference
module tb_normshift_pipe;
  typedef struct packed {
    logic [55:0] fn;
    logic [10:0] en;
    logic [10:0] eni;
    logic        tiny;
    logic        ovf1;
  } res_t;
  logic clk, rst_n;
  int   n_chk = 0, n_err = 0;
  res_t q[$];
  normshift_pipe_if bus ();
  normshift_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // value = fr * 2^(er-55); place the leading one at bit 55 (or at the EMIN-denormal slot)
  function automatic res_t model(input logic [56:0] fr, input int er, input bit ovfen, input bit unfen);
    res_t r;
    int p, e1, sh, k, enx;
    bit tiny, ovf1, st;
    logic [63:0] v, res;
    r = '0;
    if (fr == 0) begin
      r.eni = 11'd1;
      return r;
    end
    p = 0;
    for (int i = 0; i < 57; i++) if (fr[i]) p = i;
    e1 = er + p - 55;
    tiny = e1 < -1022;
    ovf1 = e1 > 1023;
    sh = (tiny && !unfen) ? (55 - (-1022 - e1)) - p : 55 - p;
    v = 64'(fr);
    st = 0;
    if (sh >= 0) res = v << sh;
    else begin
      k = -sh;
      if (k >= 57) begin
        res = 0;
        st = 1;
      end else begin
        res = v >> k;
        st = (v & ((64'd1 << k) - 64'd1)) != 0;
      end
    end
    r.fn = res[55:0] | {55'd0, st};
    enx = (tiny && !unfen) ? 0 : tiny ? e1 + 1536 + 1023 : (ovf1 && ovfen) ? e1 - 1536 + 1023
        : ovf1 ? 2047 : e1 + 1023;
    r.en = 11'(enx);
    r.eni = 11'(enx + 1);
    r.tiny = tiny;
    r.ovf1 = ovf1;
    return r;
  endfunction
  function automatic logic [56:0] rand_fr();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return 57'(r >> $urandom_range(0, 63));
  endfunction
  function automatic int rand_er();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 8191)) - 4096;
      1: return int'($urandom_range(0, 200)) - 1100;
      2: return int'($urandom_range(0, 200)) + 930;
      default: return int'($urandom_range(0, 120)) - 60;
    endcase
  endfunction
  task automatic cycle(input bit v, input logic [56:0] f, input int e, input bit o, input bit u,
                       input bit rdy, output bit acc);
    @(negedge clk);
    bus.in_valid = v;
    bus.fr = f;
    bus.er = 13'(e);
    bus.OVFen = o;
    bus.UNFen = u;
    bus.out_ready = rdy;
    #4;
    acc = v && bus.in_ready;
    if (acc) q.push_back(model(f, e, o, u));
  endtask
  task automatic send(input logic [56:0] f, input int e, input bit o, input bit u, input bit rnd);
    bit acc;
    acc = 0;
    for (int i = 0; i < 64 && !acc; i++) cycle(1, f, e, o, u, rnd ? ($urandom_range(0, 3) != 0) : 1'b1, acc);
    n_chk++;
    if (!acc) begin
      n_err++;
      $display("FAIL accept_timeout accepted=%b want 1", acc);
    end
  endtask
  task automatic drain();
    bit acc;
    for (int i = 0; i < 64 && q.size() != 0; i++) cycle(0, '0, 0, 0, 0, 1, acc);
    cycle(0, '0, 0, 0, 0, 1, acc);
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    bus.in_valid = 0;
    bus.out_ready = 0;
    #4;
    q.delete();
    @(negedge clk);
    rst_n = 1;
    bus.out_ready = 1;
    #4;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.fn !== '0 || bus.en !== '0) begin
      n_err++;
      $display("FAIL mid_reset out_valid=%b fn=%h en=%0d want 0 0 0", bus.out_valid, bus.fn, bus.en);
    end
  endtask
  initial begin
    res_t got, snap, exp;
    bit held;
    held = 0;
    snap = '0;
    forever begin
      @(negedge clk);
      #4;
      got = '{fn: bus.fn, en: bus.en, eni: bus.eni, tiny: bus.TINY, ovf1: bus.OVF1};
      if (!rst_n) held = 0;
      else begin
        n_chk++;
        if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
          n_err++;
          $display("FAIL in_ready got=%b want=%b", bus.in_ready, !bus.out_valid || bus.out_ready);
        end
        if (held) begin
          n_chk++;
          if (bus.out_valid !== 1'b1 || got !== snap) begin
            n_err++;
            $display("FAIL stall_hold got v=%b fn=%h en=%0d want v=1 fn=%h en=%0d",
                     bus.out_valid, got.fn, got.en, snap.fn, snap.en);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          n_chk++;
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL spurious_result got fn=%h en=%0d want no result", got.fn, got.en);
          end else begin
            exp = q.pop_front();
            if (got !== exp) begin
              n_err++;
              $display("FAIL result got fn=%h en=%0d eni=%0d tiny=%b ovf1=%b want fn=%h en=%0d eni=%0d tiny=%b ovf1=%b",
                       got.fn, got.en, got.eni, got.tiny, got.ovf1, exp.fn, exp.en, exp.eni, exp.tiny, exp.ovf1);
            end
          end
        end
        held = bus.out_valid && !bus.out_ready;
        snap = got;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bit acc;
    int sent;
    logic [56:0] cf;
    int ce;
    rst_n = 0;
    bus.in_valid = 0;
    bus.fr = '0;
    bus.er = '0;
    bus.OVFen = 0;
    bus.UNFen = 0;
    bus.out_ready = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    #4;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.fn !== '0 || bus.en !== '0 || bus.eni !== '0 || bus.TINY !== 1'b0 || bus.OVF1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state v=%b fn=%h en=%0d eni=%0d tiny=%b ovf1=%b want all 0",
               bus.out_valid, bus.fn, bus.en, bus.eni, bus.TINY, bus.OVF1);
    end
    send(57'd1 << 55, 0, 0, 0, 0);
    send((57'd1 << 56) | 57'd1, 5, 0, 0, 0);
    send(57'd1, 0, 0, 0, 0);
    send(57'd1 << 55, -1030, 0, 0, 0);
    send(57'd1 << 55, -1030, 0, 1, 0);
    send(57'd1 << 55, 1024, 1, 0, 0);
    send(57'd1 << 55, 1024, 0, 0, 0);
    send(57'd0, 1234, 0, 0, 0);
    send(57'd0, -3000, 1, 1, 0);
    send(57'd1 << 55, -2000, 0, 0, 0);
    send(57'd1 << 55, -1022, 0, 0, 0);
    send(57'd1 << 55, -1023, 0, 0, 0);
    send(57'd1 << 55, 1023, 0, 0, 0);
    send(57'd1 << 56, 1023, 0, 0, 0);
    send(57'h1ffffffffffffff, -1080, 0, 0, 0);
    send(57'd3, -1000, 0, 0, 0);
    drain();
    sent = 0;
    cf = rand_fr();
    ce = rand_er();
    for (int c = 0; c < 40; c++) begin
      cycle(sent < 6, cf, ce, 1'($urandom), 1'($urandom), !(c >= 4 && c <= 7), acc);
      if (acc) begin
        sent++;
        cf = rand_fr();
        ce = rand_er();
      end
    end
    n_chk++;
    if (sent != 6 || q.size() != 0) begin
      n_err++;
      $display("FAIL stall_stream sent=%0d pending=%0d want 6 0", sent, q.size());
    end
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      send(rand_fr(), rand_er(), 1'($urandom), 1'($urandom), 1);
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
